// File: rtl/multi_run_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_run_controller_pkg : shared state encoding and AES round defaults  |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package multi_run_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ROUND = 2'd2,
      ST_FINAL = 2'd3
   } ctrl_state_t;

   // Round count per AES key size; anything unrecognised falls back to AES-128.
   function automatic int aes_rounds(input int key_bits);
      case (key_bits)
         192:     return 12;
         256:     return 14;
         default: return 10;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_run_controller_blk_down_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blk_down_counter : loadable, non-wrapping down counter for burst blocks  |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module blk_down_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   always_ff @(posedge clk) begin
      if (!rst_ || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign last = (count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/multi_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_run_controller : sequences an AES round datapath over a burst of   |
// | blocks. Optional abort input enabled by defining MULTI_RUN_ABORT_EN.     |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module multi_run_controller
   import multi_run_controller_pkg::*;
#(
   parameter int NUM_ROUNDS = aes_rounds(128),
   parameter int CNT_W      = 4,
   parameter int BLK_W      = 8
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             start,
   input  logic [BLK_W-1:0] num_blocks,
   input  logic             done,
`ifdef MULTI_RUN_ABORT_EN
   input  logic             abort,
`endif
   output logic             init,
   output logic             ctrl1,
   output logic             ctrl2,
   output logic [CNT_W-1:0] round,
   output logic             busy,
   output logic             block_valid,
   output logic             burst_done
);

   localparam logic [CNT_W-1:0] LAST_RND  = CNT_W'(NUM_ROUNDS - 1);
   localparam logic [CNT_W-1:0] FINAL_RND = CNT_W'(NUM_ROUNDS);

   ctrl_state_t      state, next_state;
   logic [CNT_W-1:0] round_d;
   logic             load_cnt, dec_cnt, blk_fire, burst_fire;
   logic             abort_hit;
   logic             blk_last;
   logic [BLK_W-1:0] blk_left;

`ifdef MULTI_RUN_ABORT_EN
   assign abort_hit = abort && (state != ST_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   blk_down_counter #(.WIDTH(BLK_W)) u_blk_cnt (
      .clk      (clk),
      .rst_     (rst_),
      .clr      (abort_hit),
      .load     (load_cnt),
      .load_val (num_blocks),
      .dec      (dec_cnt),
      .count    (blk_left),
      .last     (blk_last)
   );

   always_comb begin
      next_state = state;
      load_cnt   = 1'b0;
      dec_cnt    = 1'b0;
      blk_fire   = 1'b0;
      burst_fire = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start && (num_blocks != '0)) begin
               next_state = ST_LOAD;
               load_cnt   = 1'b1;
            end
         end
         ST_LOAD:  next_state = ST_ROUND;
         ST_ROUND: begin
            if (done && (round == LAST_RND)) next_state = ST_FINAL;
         end
         ST_FINAL: begin
            if (done) begin
               dec_cnt    = 1'b1;
               blk_fire   = 1'b1;
               burst_fire = blk_last;
               next_state = blk_last ? ST_IDLE : ST_LOAD;
            end
         end
         default: next_state = ST_IDLE;
      endcase
      // Abort wins over everything, including a completing block.
      if (abort_hit) begin
         next_state = ST_IDLE;
         load_cnt   = 1'b0;
         dec_cnt    = 1'b0;
         blk_fire   = 1'b0;
         burst_fire = 1'b0;
      end
   end

   always_comb begin
      round_d = '0;
      unique case (next_state)
         ST_ROUND: begin
            if (state == ST_LOAD)                  round_d = CNT_W'(1);
            else if (done && (round != FINAL_RND)) round_d = round + 1'b1;
            else                                   round_d = round;
         end
         ST_FINAL: round_d = FINAL_RND;
         default:  round_d = '0;
      endcase
   end

   // Outputs are registered from next_state so they line up with the state's own cycle.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state       <= ST_IDLE;
         init        <= 1'b0;
         ctrl1       <= 1'b0;
         ctrl2       <= 1'b0;
         round       <= '0;
         busy        <= 1'b0;
         block_valid <= 1'b0;
         burst_done  <= 1'b0;
      end else begin
         state       <= next_state;
         init        <= (next_state == ST_LOAD);
         ctrl1       <= (next_state == ST_LOAD);
         ctrl2       <= (next_state == ST_FINAL);
         round       <= round_d;
         busy        <= (next_state != ST_IDLE);
         block_valid <= blk_fire;
         burst_done  <= burst_fire;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_run_controller.sv
`default_nettype none
// Self-checking bench for multi_run_controller: random done/start stimulus against
// a block-counting reference model, plus directed reset, stall and abort scenarios.
module tb_multi_run_controller;

   localparam int NR   = 10;
   localparam int MAXC = 2048;

   logic       clk = 1'b0;
   logic       rst_, start, done;
   logic [7:0] num_blocks;
   logic       init, ctrl1, ctrl2, busy, block_valid, burst_done;
   logic [3:0] round;
`ifdef MULTI_RUN_ABORT_EN
   logic       abort = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   logic       dn     [MAXC];
   logic       sv     [MAXC];
   logic       e_init [MAXC];
   logic       e_c1   [MAXC];
   logic       e_c2   [MAXC];
   logic       e_busy [MAXC];
   logic       e_bv   [MAXC];
   logic       e_bd   [MAXC];
   logic [3:0] e_rnd  [MAXC];
   int         ncyc;
   int         bv_at[$];

   always #5 clk = ~clk;

   multi_run_controller #(.NUM_ROUNDS(NR), .CNT_W(4), .BLK_W(8)) dut (
      .clk         (clk),
      .rst_        (rst_),
      .start       (start),
      .num_blocks  (num_blocks),
      .done        (done),
`ifdef MULTI_RUN_ABORT_EN
      .abort       (abort),
`endif
      .init        (init),
      .ctrl1       (ctrl1),
      .ctrl2       (ctrl2),
      .round       (round),
      .busy        (busy),
      .block_valid (block_valid),
      .burst_done  (burst_done)
   );

   // Reference model: cycle 0 is the LOAD cycle after the start edge. Each block
   // needs NR done-high samples after its LOAD cycle; the round shown is one more
   // than the dones already counted, and NR (with ctrl2) once NR-1 are counted.
   task automatic build_model(input int nblk, input int pct, input bit stall);
      int phase, d, left, s5, sf;
      bit bvn, bdn, hold;
      phase = 1; d = 0; left = nblk; s5 = 0; sf = 0; bvn = 0; bdn = 0; ncyc = 0;
      for (int c = 0; c < MAXC; c++) begin
         e_bv[c] = bvn; e_bd[c] = bdn; bvn = 0; bdn = 0;
         if (stall) begin
            hold = 0;
            if (phase == 2 && d == 4 && s5 < 3) begin hold = 1; s5++; end
            else if (phase == 2 && d == NR-1 && sf < 2) begin hold = 1; sf++; end
            dn[c] = !hold;
         end else begin
            dn[c] = ($urandom_range(99) < pct);
         end
         sv[c] = (phase != 0) ? 1'($urandom_range(1)) : 1'b0;
         case (phase)
            0: begin
               e_init[c] = 0; e_c1[c] = 0; e_c2[c] = 0; e_rnd[c] = 0; e_busy[c] = 0;
            end
            1: begin
               e_init[c] = 1; e_c1[c] = 1; e_c2[c] = 0; e_rnd[c] = 0; e_busy[c] = 1;
               phase = 2; d = 0;
            end
            default: begin
               e_init[c] = 0; e_c1[c] = 0; e_busy[c] = 1;
               if (d < NR-1) begin e_rnd[c] = 4'(d + 1); e_c2[c] = 0; end
               else          begin e_rnd[c] = 4'(NR);    e_c2[c] = 1; end
               if (dn[c]) begin
                  d++;
                  if (d == NR) begin
                     bvn = 1; left--;
                     if (left == 0) begin bdn = 1; phase = 0; end
                     else phase = 1;
                  end
               end
            end
         endcase
         ncyc = c + 1;
         if (e_busy[c] == 1'b0) break;
      end
   endtask

   // Called about 1 time unit after a rising edge with the DUT idle.
   task automatic run_burst(input int nblk, input int pct, input bit stall);
      int nbv;
      build_model(nblk, pct, stall);
      bv_at.delete();
      nbv = 0;
      start = 1; num_blocks = 8'(nblk); done = 0;
      @(posedge clk); #1;
      for (int c = 0; c < ncyc; c++) begin
         start = sv[c]; num_blocks = 8'($urandom); done = dn[c];
         @(negedge clk);
         total++;
         if ({init, ctrl1, ctrl2, busy, round} !== {e_init[c], e_c1[c], e_c2[c], e_busy[c], e_rnd[c]}) begin
            bad++;
            $display("FAIL ctrl cycle %0d: got init/ctrl1/ctrl2/busy/round=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                     c, init, ctrl1, ctrl2, busy, round, e_init[c], e_c1[c], e_c2[c], e_busy[c], e_rnd[c]);
         end
         total++;
         if ({block_valid, burst_done} !== {e_bv[c], e_bd[c]}) begin
            bad++;
            $display("FAIL pulses cycle %0d: got block_valid/burst_done=%b/%b want %b/%b",
                     c, block_valid, burst_done, e_bv[c], e_bd[c]);
         end
         if (block_valid === 1'b1) begin nbv++; bv_at.push_back(c); end
         @(posedge clk); #1;
      end
      start = 0; done = 0;
      total++;
      if (nbv != nblk) begin
         bad++;
         $display("FAIL block_count: got %0d want %0d", nbv, nblk);
      end
   endtask

   task automatic test_reset();
      rst_ = 0; start = 1; num_blocks = 8'd5; done = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({init, ctrl1, ctrl2, busy, block_valid, burst_done, round} !== 10'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0", {init, ctrl1, ctrl2, busy, block_valid, burst_done, round});
      end
      rst_ = 1; start = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || init !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: got busy=%b init=%b want 0/0", busy, init);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      run_burst(1, 100, 0);
      total++;
      if (bv_at.size() != 1 || bv_at[0] != NR + 1) begin
         bad++;
         $display("FAIL single_latency: got cycle %0d want %0d", (bv_at.size() > 0) ? bv_at[0] : -1, NR + 1);
      end
   endtask

   task automatic test_burst();
      run_burst(3, 100, 0);
      total++;
      if (bv_at.size() != 3 || bv_at[1] - bv_at[0] != NR + 1 || bv_at[2] - bv_at[1] != NR + 1) begin
         bad++;
         $display("FAIL burst_spacing: got %0d pulses, first gap %0d want 3 pulses gap %0d",
                  bv_at.size(), (bv_at.size() > 1) ? bv_at[1] - bv_at[0] : -1, NR + 1);
      end
      start = 1; num_blocks = 8'd0; done = 1;
      @(posedge clk); #1;
      start = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_blocks: got busy=%b want 0", busy);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stalls();
      run_burst(1, 0, 1);
      total++;
      if (bv_at.size() != 1 || bv_at[0] != NR + 1 + 5) begin
         bad++;
         $display("FAIL stall_latency: got cycle %0d want %0d", (bv_at.size() > 0) ? bv_at[0] : -1, NR + 6);
      end
      for (int k = 0; k < 4; k++) run_burst($urandom_range(4, 1), $urandom_range(90, 40), 0);
   endtask

   task automatic test_reset_mid();
      start = 1; num_blocks = 8'd4; done = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (2*NR - 3) @(posedge clk);  // into cycle 17: block 2, round 6
      #1;
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || round !== 4'd6 || ctrl2 !== 1'b0) begin
         bad++;
         $display("FAIL mid_pre: got busy=%b round=%0d ctrl2=%b want 1/6/0", busy, round, ctrl2);
      end
      rst_ = 0;
      @(posedge clk); #1;
      rst_ = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({init, ctrl1, ctrl2, busy, block_valid, burst_done, round} !== 10'd0) begin
            bad++;
            $display("FAIL mid_reset cycle %0d: got %b want 0", i,
                     {init, ctrl1, ctrl2, busy, block_valid, burst_done, round});
         end
         @(posedge clk); #1;
      end
      run_burst(2, 80, 0);
   endtask

`ifdef MULTI_RUN_ABORT_EN
   task automatic test_abort();
      bit seen_bd;
      start = 1; num_blocks = 8'd2; done = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (NR) @(posedge clk);  // into cycle 10: FINAL of block 1
      #1;
      abort = 1;
      @(negedge clk);
      total++;
      if (ctrl2 !== 1'b1) begin
         bad++;
         $display("FAIL abort_pre: got ctrl2=%b want 1", ctrl2);
      end
      @(posedge clk); #1;
      abort = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if ({init, ctrl1, ctrl2, busy, block_valid, burst_done, round} !== 10'd0) begin
            bad++;
            $display("FAIL abort_final cycle %0d: got %b want 0", i,
                     {init, ctrl1, ctrl2, busy, block_valid, burst_done, round});
         end
         @(posedge clk); #1;
      end
      abort = 1; start = 1; num_blocks = 8'd1;
      @(posedge clk); #1;
      abort = 0; start = 0;
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || init !== 1'b1) begin
         bad++;
         $display("FAIL abort_idle: got busy=%b init=%b want 1/1", busy, init);
      end
      seen_bd = 0;
      for (int i = 0; i < 4*NR && !seen_bd; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (burst_done === 1'b1) seen_bd = 1;
      end
      total++;
      if (!seen_bd) begin
         bad++;
         $display("FAIL abort_idle_burst: got no burst_done want one");
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ = 0; start = 0; done = 0; num_blocks = 0;
      test_reset();
      test_single();
      test_burst();
      test_stalls();
      test_reset_mid();
`ifdef MULTI_RUN_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
